inst_line_buf: RTL and testbench

INST_LINE_BUF -- requirements
Module: inst_line_buf

---
 rtl/inst_line_buf.sv | 114 +++++++++++
 tb/tb_inst_line_buf.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_line_buf.sv
// Single-line instruction buffer: serves hits from one resident line and
// refills the whole line from external memory on a miss.
module inst_line_buf #(
   parameter int unsigned LINE_LOG2 = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rom_ce_i,
   input  logic [31:0] rom_addr_i,
   output logic [31:0] rom_data_o,
   output logic        stallreq_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_data_i
);

   localparam int unsigned WORDS = 1 << LINE_LOG2;
   localparam int unsigned OFF_W = LINE_LOG2 + 2;
   localparam int unsigned TAG_W = 32 - OFF_W;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [LINE_LOG2-1:0] cnt_q, cnt_d;
   logic                 valid_q, valid_d;
   logic [TAG_W-1:0]     tag_q, tag_d;
   logic [31:0]          base_q, base_d;
   logic [31:0]          line_q [WORDS];
   logic [31:0]          line_d [WORDS];

   logic                 hit_c;
   logic                 miss_c;
   logic [LINE_LOG2-1:0] word_sel_c;

   // Hit/miss decode against the resident line
   always_comb begin
      word_sel_c = rom_addr_i[OFF_W-1:2];
      hit_c      = (state_q == ST_IDLE) && rom_ce_i && valid_q &&
                   (tag_q == rom_addr_i[31:OFF_W]);
      miss_c     = (state_q == ST_IDLE) && rom_ce_i && !hit_c;
   end

   // Next-state: latch line base on a miss, then collect one word per ack
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      tag_d   = tag_q;
      base_d  = base_q;
      line_d  = line_q;
      case (state_q)
         ST_IDLE: begin
            if (miss_c) begin
               base_d  = rom_addr_i & ~32'(WORDS * 4 - 1);
               cnt_d   = '0;
               valid_d = 1'b0;
               state_d = ST_FILL;
            end
         end
         ST_FILL: begin
            if (mem_ack_i) begin
               line_d[cnt_q] = mem_data_i;
               cnt_d         = cnt_q + LINE_LOG2'(1);
               if (cnt_q == LINE_LOG2'(WORDS - 1)) begin
                  tag_d   = base_q[31:OFF_W];
                  valid_d = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and line storage registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         tag_q   <= '0;
         base_q  <= '0;
         for (int i = 0; i < WORDS; i++) line_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         tag_q   <= tag_d;
         base_q  <= base_d;
         for (int i = 0; i < WORDS; i++) line_q[i] <= line_d[i];
      end
   end

   // Core and memory side outputs; forced quiet while reset is held
   always_comb begin
      rom_data_o = '0;
      stallreq_o = 1'b0;
      mem_req_o  = 1'b0;
      mem_addr_o = '0;
      if (!rst) begin
         if (hit_c) rom_data_o = line_q[word_sel_c];
         stallreq_o = miss_c || (state_q == ST_FILL);
         if (state_q == ST_FILL) begin
            mem_req_o  = 1'b1;
            mem_addr_o = base_q + 32'({cnt_q, 2'b00});
         end
      end
   end

endmodule

// File: tb/tb_inst_line_buf.sv
// Self-checking bench for inst_line_buf: memory model plus expected-address scoreboard.
module tb_inst_line_buf;

   logic        clk;
   logic        rst;
   logic        rom_ce_i;
   logic [31:0] rom_addr_i;
   logic [31:0] rom_data_o;
   logic        stallreq_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ack_i;
   logic [31:0] mem_data_i;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] exp_q[$];

   inst_line_buf #(.LINE_LOG2(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .rom_ce_i   (rom_ce_i),
      .rom_addr_i (rom_addr_i),
      .rom_data_o (rom_data_o),
      .stallreq_o (stallreq_o),
      .mem_req_o  (mem_req_o),
      .mem_addr_o (mem_addr_o),
      .mem_ack_i  (mem_ack_i),
      .mem_data_i (mem_data_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External memory contents: a pure function of the word address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h0000_1000 + (a >> 2);
   endfunction

   // One fetch; acks every 'period' cycles while filling; ends at posedge+1
   task automatic fetch(input logic [31:0] a, input bit exp_miss, input int period);
      int stalls;
      int wctr;
      bit done;
      logic [31:0] base;
      stalls = 0;
      wctr   = 0;
      done   = 1'b0;
      base   = a & 32'hFFFF_FFF0;
      rom_ce_i   = 1'b1;
      rom_addr_i = a;
      if (exp_miss)
         for (int i = 0; i < 4; i++) exp_q.push_back(base + 32'(4 * i));
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk);
         if (!stallreq_o) begin
            done = 1'b1;
         end else begin
            stalls++;
            if (mem_req_o) begin
               n_tests++;
               if (exp_q.size() == 0 || mem_addr_o !== exp_q[0]) begin
                  n_fail++;
                  $display("FAIL mem_addr fetch=%h got=%h want=%h", a, mem_addr_o,
                           (exp_q.size() != 0) ? exp_q[0] : 32'hx);
               end
               wctr++;
               if (wctr == period) begin
                  wctr       = 0;
                  mem_ack_i  = 1'b1;
                  mem_data_i = mem_word(mem_addr_o);
                  if (exp_q.size() != 0) void'(exp_q.pop_front());
               end
            end
            @(posedge clk);
            #1;
            mem_ack_i  = 1'b0;
            mem_data_i = 32'hDEAD_BEEF;
         end
      end
      n_tests++;
      if (!done) begin
         n_fail++;
         $display("FAIL fetch_timeout addr=%h got=stalled want=done", a);
      end
      n_tests++;
      if (stalls != (exp_miss ? 1 + 4 * period : 0)) begin
         n_fail++;
         $display("FAIL stall_cycles addr=%h got=%0d want=%0d", a, stalls,
                  exp_miss ? 1 + 4 * period : 0);
      end
      n_tests++;
      if (rom_data_o !== mem_word(a)) begin
         n_fail++;
         $display("FAIL rom_data addr=%h got=%h want=%h", a, rom_data_o, mem_word(a));
      end
      n_tests++;
      if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0) begin
         n_fail++;
         $display("FAIL idle_mem addr=%h got=%b/%h want=0/0", a, mem_req_o, mem_addr_o);
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_left addr=%h got=%0d want=0", a, exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   // Outputs stay quiet while reset is held, whatever the inputs do
   task automatic test_reset();
      rst        = 1'b1;
      rom_ce_i   = 1'b1;
      rom_addr_i = 32'h0000_0008;
      mem_ack_i  = 1'b1;
      mem_data_i = 32'h1234_5678;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_tests++;
         if (rom_data_o !== 32'h0 || stallreq_o !== 1'b0 ||
             mem_req_o !== 1'b0 || mem_addr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h/%b/%b/%h want=0/0/0/0",
                     rom_data_o, stallreq_o, mem_req_o, mem_addr_o);
         end
      end
      @(posedge clk);
      #1;
      rst       = 1'b0;
      rom_ce_i  = 1'b0;
      mem_ack_i = 1'b0;
   endtask

   // Cold miss at 0x8 followed by consecutive hits in the same line
   task automatic test_cold_miss_hits();
      fetch(32'h0000_0008, 1'b1, 1);
      fetch(32'h0000_0000, 1'b0, 1);
      fetch(32'h0000_0004, 1'b0, 1);
      fetch(32'h0000_000C, 1'b0, 1);
   endtask

   // ce low with a spurious ack: quiet outputs and resident line untouched
   task automatic test_ce_low();
      for (int c = 0; c < 4; c++) begin
         rom_ce_i   = 1'b0;
         rom_addr_i = $urandom;
         mem_ack_i  = 1'b1;
         mem_data_i = $urandom;
         @(negedge clk);
         n_tests++;
         if (rom_data_o !== 32'h0 || stallreq_o !== 1'b0 || mem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ce_low got=%h/%b/%b want=0/0/0", rom_data_o, stallreq_o, mem_req_o);
         end
         @(posedge clk);
         #1;
      end
      mem_ack_i = 1'b0;
      fetch(32'h0000_0004, 1'b0, 1);
   endtask

   // Slow memory: one ack every third cycle
   task automatic test_wait_states();
      fetch(32'h0000_0020, 1'b1, 3);
      fetch(32'h0000_0024, 1'b0, 1);
      fetch(32'h0000_002C, 1'b0, 1);
   endtask

   // Replacing the single line evicts the previous one
   task automatic test_replacement();
      fetch(32'h0000_0000, 1'b1, 1);
      fetch(32'h0000_0010, 1'b1, 1);
      fetch(32'h0000_0018, 1'b0, 1);
      fetch(32'h0000_0000, 1'b1, 1);
   endtask

   // Reset after two acks abandons the fill; refetch performs a full fill
   task automatic test_reset_mid_fill();
      rom_ce_i   = 1'b1;
      rom_addr_i = 32'h0000_0044;
      @(negedge clk);
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_tests++;
         if (mem_req_o !== 1'b1 || mem_addr_o !== 32'(32'h40 + 4 * i)) begin
            n_fail++;
            $display("FAIL midfill_addr got=%b/%h want=1/%h", mem_req_o, mem_addr_o,
                     32'(32'h40 + 4 * i));
         end
         mem_ack_i  = 1'b1;
         mem_data_i = mem_word(mem_addr_o);
         @(posedge clk);
         #1;
         mem_ack_i = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      rom_ce_i = 1'b0;
      @(negedge clk);
      n_tests++;
      if (mem_req_o !== 1'b0 || stallreq_o !== 1'b0) begin
         n_fail++;
         $display("FAIL after_reset got=%b/%b want=0/0", mem_req_o, stallreq_o);
      end
      @(posedge clk);
      #1;
      fetch(32'h0000_0044, 1'b1, 1);
   endtask

   initial begin
      rst        = 1'b1;
      rom_ce_i   = 1'b0;
      rom_addr_i = 32'h0;
      mem_ack_i  = 1'b0;
      mem_data_i = 32'h0;
      @(posedge clk);
      #1;
      test_reset();
      test_cold_miss_hits();
      test_ce_low();
      test_wait_states();
      test_replacement();
      test_reset_mid_fill();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
